// File: rtl/udma_stream_sink.sv
// udma_stream_sink: uDMA outbound stream receiver. It packs beats little-endian into 32-bit words behind a FWFT FIFO.
// Build option UDMA_STREAM_SINK_DROP_EN: beats arriving outside a frame without sot are discarded instead of opening an implicit frame.
module udma_stream_sink #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TRANS_SIZE = 20
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [31:0]           stream_data_i,
  input  logic [1:0]            stream_datasize_i,
  input  logic                  stream_valid_i,
  input  logic                  stream_sot_i,
  input  logic                  stream_eot_i,
  output logic                  stream_ready_o,
  output logic [31:0]           word_data_o,
  output logic [3:0]            word_be_o,
  output logic                  word_last_o,
  output logic                  word_valid_o,
  input  logic                  word_ready_i,
  output logic                  frame_done_o,
  output logic [TRANS_SIZE-1:0] frame_len_o,
  output logic                  err_o,
  input  logic                  err_clr_i
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [TRANS_SIZE-1:0] CntMax = '1;

`ifdef UDMA_STREAM_SINK_DROP_EN
  localparam bit DropEn = 1'b1;
`else
  localparam bit DropEn = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
    logic        last;
  } word_t;

  word_t                 mem_q [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_q, rd_ptr_q;
  logic [31:0]           pack_q, pack_d;
  logic [3:0]            pack_be_q, pack_be_d;
  logic [2:0]            off_q, off_d;
  logic                  in_frame_q, in_frame_d;
  logic [TRANS_SIZE-1:0] cnt_q, cnt_d;
  logic [TRANS_SIZE-1:0] len_q, len_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [2:0]            nbytes_c;
  logic [3:0]            beat_mask_c;
  logic [31:0]           beat_bits_c;
  logic [31:0]           lane_data_c;
  logic [3:0]            lane_be_c;
  logic [31:0]           pack_nx_c;
  logic [3:0]            pack_be_nx_c;
  logic [2:0]            off_nx_c;
  logic                  overflow_c, conflict_c;
  logic                  fifo_full_c, fifo_empty_c;
  logic                  stall_c, accept_c, pop_c;
  logic                  starts_c, discard_c;
  logic [TRANS_SIZE:0]   sum_c;
  logic [TRANS_SIZE-1:0] cnt_new_c;
  logic                  push_c;
  word_t                 push_word_c;
  word_t                 head_c;

  // Beat width decode and lane placement at the current byte offset
  always_comb begin
    unique case (stream_datasize_i)
      2'd0:    begin nbytes_c = 3'd1; beat_mask_c = 4'b0001; end
      2'd1:    begin nbytes_c = 3'd2; beat_mask_c = 4'b0011; end
      default: begin nbytes_c = 3'd4; beat_mask_c = 4'b1111; end
    endcase
    for (int i = 0; i < 4; i++) begin
      beat_bits_c[i*8 +: 8] = {8{beat_mask_c[i]}};
    end
    lane_data_c  = (stream_data_i & beat_bits_c) << {off_q[1:0], 3'b000};
    lane_be_c    = beat_mask_c << off_q[1:0];
    pack_nx_c    = pack_q | lane_data_c;
    pack_be_nx_c = pack_be_q | lane_be_c;
    off_nx_c     = off_q + nbytes_c;
  end

  // Ready never looks at stream_valid_i; the pending terms only use the beat's size/sot fields
  always_comb begin
    fifo_empty_c   = (wr_ptr_q == rd_ptr_q);
    fifo_full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    overflow_c     = ({1'b0, off_q} + {1'b0, nbytes_c}) > 4'd4;
    conflict_c     = stream_sot_i & in_frame_q;
    stream_ready_o = enable_i & ~fifo_full_c & ~(overflow_c | conflict_c);
    stall_c        = enable_i & ~fifo_full_c & stream_valid_i & (overflow_c | conflict_c);
    accept_c       = stream_valid_i & stream_ready_o;
    pop_c          = ~fifo_empty_c & word_ready_i;
    discard_c      = DropEn && !in_frame_q && !stream_sot_i;
    starts_c       = stream_sot_i || (!in_frame_q && !DropEn);
    sum_c          = {1'b0, cnt_q} + (TRANS_SIZE+1)'(nbytes_c);
    cnt_new_c      = starts_c ? TRANS_SIZE'(nbytes_c)
                   : (sum_c[TRANS_SIZE] ? CntMax : sum_c[TRANS_SIZE-1:0]);
  end

  // Pack, flush and framing next-state
  always_comb begin
    pack_d      = pack_q;
    pack_be_d   = pack_be_q;
    off_d       = off_q;
    in_frame_d  = in_frame_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    done_d      = 1'b0;
    err_d       = err_q & ~err_clr_i;
    push_c      = 1'b0;
    push_word_c = '0;

    if (stall_c && conflict_c) begin
      push_c      = 1'b1;
      push_word_c = {pack_q, pack_be_q, 1'b1};
      pack_d      = '0;
      pack_be_d   = '0;
      off_d       = '0;
      in_frame_d  = 1'b0;
      len_d       = cnt_q;
      done_d      = 1'b1;
      err_d       = 1'b1;
    end else if (stall_c) begin
      push_c      = 1'b1;
      push_word_c = {pack_q, pack_be_q, 1'b0};
      pack_d      = '0;
      pack_be_d   = '0;
      off_d       = '0;
    end else if (accept_c) begin
      if (stream_datasize_i == 2'd3 || (!in_frame_q && !stream_sot_i)) begin
        err_d = 1'b1;
      end
      if (!discard_c) begin
        cnt_d      = cnt_new_c;
        in_frame_d = ~stream_eot_i;
        if (off_nx_c == 3'd4 || stream_eot_i) begin
          push_c      = 1'b1;
          push_word_c = {pack_nx_c, pack_be_nx_c, stream_eot_i};
          pack_d      = '0;
          pack_be_d   = '0;
          off_d       = '0;
        end else begin
          pack_d    = pack_nx_c;
          pack_be_d = pack_be_nx_c;
          off_d     = off_nx_c;
        end
        if (stream_eot_i) begin
          len_d  = cnt_new_c;
          done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[AW'(i)] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pack_q     <= '0;
      pack_be_q  <= '0;
      off_q      <= '0;
      in_frame_q <= 1'b0;
      cnt_q      <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pack_q     <= pack_d;
      pack_be_q  <= pack_be_d;
      off_q      <= off_d;
      in_frame_q <= in_frame_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      done_q     <= done_d;
      err_q      <= err_d;
      if (push_c) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_word_c;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  assign head_c       = mem_q[rd_ptr_q[AW-1:0]];
  assign word_data_o  = head_c.data;
  assign word_be_o    = head_c.be;
  assign word_last_o  = head_c.last;
  assign word_valid_o = ~fifo_empty_c;
  assign frame_done_o = done_q;
  assign frame_len_o  = len_q;
  assign err_o        = err_q;

endmodule
